// File: rtl/demod_ppm.sv
// rtl/demod_ppm.sv - receive-side PPM demodulator with frame sync on the rising edge of i_busy
//
// Purpose:
//   Opens a 2^N-slot window on each rising edge of i_busy. The window starts
//   one cycle after that edge. The block records the slot of the first pulse
//   seen on i_ppm and reports it as a signed symbol, slot - 2^(N-1), with a
//   one-cycle o_valid strobe. The strobe comes one cycle after the last slot.
//
// Ports:
//   i_clk    clock, all logic on posedge
//   i_rst_n  asynchronous active-low reset
//   i_ppm    PPM pulse line, synchronous to i_clk
//   i_busy   frame-sync level; a 0->1 transition starts a frame
//   o_data   recovered signed symbol, held until the next result
//   o_valid  one-cycle strobe; o_data (and o_err) updated this cycle
//   o_busy   high while the sampling window is open
//   o_err    frame error flag qualified by o_valid (only with PPM_DEMOD_ERR_EN)
//
// Configuration:
//   PPM_DEMOD_ERR_EN  when defined, every frame produces o_valid and o_err
//                     reports zero or multiple pulses; when undefined, empty
//                     frames produce no result at all.

module demod_ppm #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_ppm,
  input  logic         i_busy,
  output logic [N-1:0] o_data,
  output logic         o_valid,
`ifdef PPM_DEMOD_ERR_EN
  output logic         o_busy,
  output logic         o_err
`else
  output logic         o_busy
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] CNT_LAST = {N{1'b1}};

  state_t       r_state;
  logic         r_busy_q;
  logic [N-1:0] r_cnt;
  logic [1:0]   r_npulse;
  logic [N-1:0] r_slot;

  logic         w_start;
  logic         w_last;
  logic [1:0]   w_npulse_nxt;
  logic [N-1:0] w_slot_nxt;
  logic [N-1:0] w_sym;

  assign w_start = i_busy & ~r_busy_q;
  assign w_last  = (r_cnt == CNT_LAST);

  // The last slot is sampled in the same cycle the result is registered,
  // so the result is built from the next-state pulse count and slot.
  always_comb begin
    w_npulse_nxt = r_npulse;
    w_slot_nxt   = r_slot;
    if (i_ppm) begin
      if (r_npulse != 2'd2) begin
        w_npulse_nxt = r_npulse + 2'd1;
      end
      if (r_npulse == 2'd0) begin
        w_slot_nxt = r_cnt;
      end
    end
  end

  // slot - 2^(N-1) in N-bit two's complement is the slot with its MSB flipped.
  assign w_sym = {~w_slot_nxt[N-1], w_slot_nxt[N-2:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_busy_q <= 1'b0;
      r_cnt    <= '0;
      r_npulse <= 2'd0;
      r_slot   <= '0;
      o_data   <= '0;
      o_valid  <= 1'b0;
      o_busy   <= 1'b0;
`ifdef PPM_DEMOD_ERR_EN
      o_err    <= 1'b0;
`endif
    end else begin
      r_busy_q <= i_busy;
      o_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state  <= ACTIVE;
            r_cnt    <= '0;
            r_npulse <= 2'd0;
            r_slot   <= '0;
            o_busy   <= 1'b1;
          end
        end
        ACTIVE: begin
          r_npulse <= w_npulse_nxt;
          r_slot   <= w_slot_nxt;
          r_cnt    <= r_cnt + CNT_ONE;
          if (w_last) begin
            r_state <= DONE;
            o_busy  <= 1'b0;
`ifdef PPM_DEMOD_ERR_EN
            o_valid <= 1'b1;
            o_err   <= (w_npulse_nxt != 2'd1);
            o_data  <= (w_npulse_nxt == 2'd0) ? '0 : w_sym;
`else
            if (w_npulse_nxt != 2'd0) begin
              o_valid <= 1'b1;
              o_data  <= w_sym;
            end
`endif
          end
        end
        DONE: begin
          // Re-arm immediately so a frame starting right behind this one is kept.
          if (w_start) begin
            r_state  <= ACTIVE;
            r_cnt    <= '0;
            r_npulse <= 2'd0;
            r_slot   <= '0;
            o_busy   <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demod_ppm.sv
// tb/tb_demod_ppm.sv - scoreboard testbench for demod_ppm

module tb_demod_ppm;

  logic       clk;
  logic       rst_n;
  logic       ppm;
  logic       busy_in;
  logic [3:0] data;
  logic       valid;
  logic       busy_out;
`ifdef PPM_DEMOD_ERR_EN
  logic       err;
`endif

  demod_ppm #(.N(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_ppm   (ppm),
    .i_busy  (busy_in),
    .o_data  (data),
    .o_valid (valid),
`ifdef PPM_DEMOD_ERR_EN
    .o_busy  (busy_out),
    .o_err   (err)
`else
    .o_busy  (busy_out)
`endif
  );

  typedef struct {
    logic [3:0] d;
    logic       e;
    int         t0;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [3:0] last_data = 4'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a frame's result is the first pulsed slot minus half the frame,
  // flagged as an error unless exactly one pulse was present.
  task automatic push_exp(input logic [15:0] m, input int t0);
    int   first;
    int   n;
    exp_t x;
    first = -1;
    n = $countones(m);
    for (int i = 0; i < 16; i++) begin
      if (m[i] && first < 0) first = i;
    end
    x.t0 = t0;
    if (n == 0) begin
`ifdef PPM_DEMOD_ERR_EN
      x.d = 4'd0;
      x.e = 1'b1;
      sb.push_back(x);
`endif
    end else begin
      x.d = 4'(first - 8);
      x.e = (n != 1);
      sb.push_back(x);
    end
  endtask

  // Monitor: the value seen at negedge after edge k is what the next edge samples.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_data = 4'd0;
    end else if (valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("data", int'(data), int'(x.d));
        chk("valid_latency", cyc + 1, x.t0 + 17);
`ifdef PPM_DEMOD_ERR_EN
        chk("err", int'(err), int'(x.e));
`endif
        last_data = x.d;
      end
    end else begin
      chk("data_hold", int'(data), int'(last_data));
    end
  end

  // Drives one frame; returns just after the edge sampling the last slot.
  task automatic frame(input logic [15:0] m, input bit toggle);
    int t0;
    busy_in = 1'b1;
    t0 = cyc + 1;
    push_exp(m, t0);
    @(posedge clk); #1;
    for (int s = 0; s < 16; s++) begin
      chk("busy_open", int'(busy_out), 1);
      ppm = m[s];
      if (toggle && s >= 3 && s <= 12) busy_in = 1'($urandom_range(0, 1));
      if (s == 13) busy_in = 1'b1;
      if (s == 15) busy_in = 1'b0;
      @(posedge clk); #1;
    end
    ppm = 1'b0;
    chk("busy_closed", int'(busy_out), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      ppm = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    ppm = 1'b0;
  endtask

  initial begin
    logic [15:0] m;
    int r;
    rst_n   = 1'b0;
    ppm     = 1'b0;
    busy_in = 1'b0;
    #1;
    chk("reset_data", int'(data), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_busy", int'(busy_out), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);

    frame(16'h2000, 1'b0); idle(3);   // slot 13 -> 5
    frame(16'h0001, 1'b0); idle(2);   // slot 0 -> -8
    frame(16'h8000, 1'b0); idle(2);   // slot 15 -> 7
    frame(16'h0000, 1'b0); idle(2);   // empty frame
    frame(16'h0208, 1'b0); idle(2);   // slots 3 and 9 -> -5

    // Reset mid-frame after a pulse at slot 2
    busy_in = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 5; s++) begin
      ppm = (s == 2);
      @(posedge clk); #1;
    end
    ppm = 1'b0;
    busy_in = 1'b0;
    chk("busy_before_reset", int'(busy_out), 1);
    chk("data_before_reset", int'(data), 11);
    rst_n = 1'b0;
    #1;
    chk("midreset_data", int'(data), 0);
    chk("midreset_valid", int'(valid), 0);
    chk("midreset_busy", int'(busy_out), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    frame(16'h0040, 1'b0); idle(2);   // slot 6 -> -2

    // Back-to-back frames with mid-window busy toggles
    frame(16'h0010, 1'b1);
    frame(16'h1000, 1'b1);
    idle(3);

    // Every symbol once, as from the modulator
    for (int s = 0; s < 16; s++) begin
      frame(16'(1 << s), 1'b0);
      idle(1 + (s % 3));
    end

    // Random frames
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      m = 16'h0000;
      else if (r <= 2) m = 16'($urandom);
      else             m = 16'(1 << $urandom_range(0, 15));
      frame(m, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) != 0) idle($urandom_range(1, 4));
    end

    idle(4);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
